control_unit_mc: RTL and testbench



---
 rtl/control_unit_pkg.sv | 59 +++++
 rtl/cu_decoder.sv | 125 ++++++++++++
 rtl/control_unit_mc.sv | 188 ++++++++++++++++++
 tb/tb_control_unit_mc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
//   - RV32I/RV64I opcode constants
//   - FSM state encoding
//   - register write-back source encodings
//   - decoder result struct and access-size to byte-lane mask helper
package control_unit_pkg;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef struct packed {
        logic       legal;
        logic       is_mem;
        logic       is_load;
        logic       is_branch;
        logic       is_halt;
        logic       jump;       // unconditional redirect (JAL/JALR)
        logic       wr_reg;
        logic       alua_src;
        logic       alub_src;
        logic       aluy_src;
        logic       sub;
        logic       arithmetic;
        logic       alupc_src;
        logic [2:0] alu_src;
        logic [1:0] wr_reg_src;
        logic [7:0] byte_mask;  // low-aligned, widest case is a doubleword
    } dec_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction classifier.
//   opcode/funct3/funct7 in  -> dec (dec_t) out: datapath selects, byte mask,
//   and the legal/is_mem/is_load/is_branch/is_halt classification.
// RV64I=0 rejects W ops, LD/SD and LWU as illegal.
module cu_decoder
    import control_unit_pkg::*;
#(
    parameter int RV64I = 0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    localparam bit RV64 = (RV64I != 0);

    // RV64 immediate shifts carry a 6-bit shamt, so funct7[0] is shamt[5].
    logic [6:0] shift_f7;
    assign shift_f7 = RV64 ? {funct7[6:1], 1'b0} : funct7;

    logic f7_zero, f7_alt;
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        dec = '0;
        case (opcode)
            LUI: begin
                dec.legal      = 1'b1;
                dec.wr_reg     = 1'b1;
                dec.wr_reg_src = WB_IMM;
            end
            AUIPC: begin
                dec.legal    = 1'b1;
                dec.alua_src = 1'b1;
                dec.alub_src = 1'b1;
                dec.wr_reg   = 1'b1;
            end
            JAL: begin
                dec.legal      = 1'b1;
                dec.jump       = 1'b1;
                dec.wr_reg     = 1'b1;
                dec.wr_reg_src = WB_PC4;
            end
            JALR: begin
                dec.legal      = (funct3 == 3'b000);
                dec.jump       = 1'b1;
                dec.alupc_src  = 1'b1;
                dec.wr_reg     = 1'b1;
                dec.wr_reg_src = WB_PC4;
            end
            BRANCH: begin
                dec.legal     = (funct3[2:1] != 2'b01);
                dec.is_branch = 1'b1;
                dec.sub       = 1'b1;
            end
            LOAD: begin
                // LB/LH/LW/LBU/LHU always; LD/LWU only in RV64 mode.
                dec.legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101) ||
                            (RV64 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
                dec.is_mem    = 1'b1;
                dec.is_load   = 1'b1;
                dec.alub_src  = 1'b1;
                dec.byte_mask = size_mask(funct3[1:0]);
            end
            STORE: begin
                dec.legal     = !funct3[2] && ((funct3[1:0] != 2'b11) || RV64);
                dec.is_mem    = 1'b1;
                dec.alub_src  = 1'b1;
                dec.byte_mask = size_mask(funct3[1:0]);
            end
            OP_IMM: begin
                case (funct3)
                    3'b001:  dec.legal = (shift_f7 == 7'b0000000);
                    3'b101:  dec.legal = (shift_f7 == 7'b0000000) || (shift_f7 == 7'b0100000);
                    default: dec.legal = 1'b1;
                endcase
                dec.alub_src   = 1'b1;
                dec.alu_src    = funct3;
                dec.arithmetic = (funct3 == 3'b101) && funct7[5];
                dec.wr_reg     = 1'b1;
            end
            OP_IMM_32: begin
                dec.legal = RV64 && ((funct3 == 3'b000) ||
                                     ((funct3 == 3'b001) && f7_zero) ||
                                     ((funct3 == 3'b101) && (f7_zero || f7_alt)));
                dec.alub_src   = 1'b1;
                dec.aluy_src   = 1'b1;
                dec.alu_src    = funct3;
                dec.arithmetic = (funct3 == 3'b101) && funct7[5];
                dec.wr_reg     = 1'b1;
            end
            OP: begin
                dec.legal      = f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.alu_src    = funct3;
                dec.sub        = (funct3 == 3'b000) && funct7[5];
                dec.arithmetic = (funct3 == 3'b101) && funct7[5];
                dec.wr_reg     = 1'b1;
            end
            OP_32: begin
                dec.legal = RV64 && ((((funct3 == 3'b000) || (funct3 == 3'b101)) && (f7_zero || f7_alt)) ||
                                     ((funct3 == 3'b001) && f7_zero));
                dec.aluy_src   = 1'b1;
                dec.alu_src    = funct3;
                dec.sub        = (funct3 == 3'b000) && funct7[5];
                dec.arithmetic = (funct3 == 3'b101) && funct7[5];
                dec.wr_reg     = 1'b1;
            end
            MISC_MEM: dec.legal = (funct3 == 3'b000);  // FENCE executes as a NOP
            SYSTEM: begin
                // Only ECALL/EBREAK are recognised; both stop the core.
                dec.legal   = (funct3 == 3'b000);
                dec.is_halt = 1'b1;
            end
            7'b0000000: begin
                dec.legal   = 1'b1;
                dec.is_halt = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit: IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ...
// Sequences memory requests against the memory controller busy handshake
// (request held until busy has been seen and then falls), drives every
// datapath select/enable, and latches HALT on illegal instructions,
// ECALL/EBREAK, opcode 0 or a bus timeout.
// Ports: clock/reset, mem_busy, instruction fields, ALU flags in;
//        memory request + byte lanes, register enables, ALU/PC/write-back
//        selects and the sticky halted/illegal_instr/bus_timeout flags out.
module control_unit_mc
    import control_unit_pkg::*;
#(
    parameter int RV64I          = 0,
    parameter int BYTE_NUM       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_busy,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                negative,
    input  logic                carry_out,
    input  logic                overflow,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [BYTE_NUM-1:0] mem_byte_en,
    output logic                ir_en,
    output logic                pc_en,
    output logic                wr_reg_en,
    output logic                alua_src,
    output logic                alub_src,
    output logic                aluy_src,
    output logic [2:0]          alu_src,
    output logic                sub,
    output logic                arithmetic,
    output logic                alupc_src,
    output logic                pc_src,
    output logic [1:0]          wr_reg_src,
    output logic                mem_addr_src,
    output logic                halted,
    output logic                illegal_instr,
    output logic                bus_timeout
);

    localparam bit         TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int         CW         = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [7:0] FETCH_MASK = 8'h0F;

    state_t        state, state_nx;
    logic          seen_busy;
    logic [CW-1:0] tmo_cnt;
    logic          illegal_q, timeout_q;
    logic          req_state, done, expired, taken, set_illegal;
    dec_t          dec;

    cu_decoder #(.RV64I(RV64I)) u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .dec    (dec)
    );

    // Lanes above BYTE_NUM are never driven on a narrow bus.
    logic unused_mask;
    assign unused_mask = ^dec.byte_mask;

    assign req_state = (state == FETCH) || ((state == EXECUTE) && dec.is_mem);
    assign done      = req_state && seen_busy && !mem_busy;
    // Expiry is judged on the current count, before this cycle's increment.
    assign expired   = TMO_EN && req_state && !done && (tmo_cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        case (funct3[2:1])
            2'b00:   taken = zero ^ funct3[0];
            2'b10:   taken = negative ^ overflow ^ funct3[0];
            2'b11:   taken = carry_out ~^ funct3[0];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            tmo_cnt   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                seen_busy <= 1'b0;
                tmo_cnt   <= '0;
            end else if (req_state) begin
                seen_busy <= seen_busy | mem_busy;
                if (TMO_EN) tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (expired)     timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        set_illegal  = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_byte_en  = '0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        wr_reg_en    = 1'b0;
        alua_src     = 1'b0;
        alub_src     = 1'b0;
        aluy_src     = 1'b0;
        alu_src      = 3'b000;
        sub          = 1'b0;
        arithmetic   = 1'b0;
        alupc_src    = 1'b0;
        pc_src       = 1'b0;
        wr_reg_src   = WB_ALU;
        mem_addr_src = 1'b0;
        // Outputs are forced low while reset is held, even mid-request.
        if (!reset) begin
            case (state)
                IDLE: state_nx = FETCH;
                FETCH: begin
                    if (done) begin
                        ir_en    = 1'b1;
                        state_nx = DECODE;
                    end else if (expired) begin
                        state_nx = HALT;
                    end else begin
                        mem_rd_en   = 1'b1;
                        mem_byte_en = FETCH_MASK[BYTE_NUM-1:0];
                    end
                end
                DECODE: begin
                    if (!dec.legal) begin
                        set_illegal = 1'b1;
                        state_nx    = HALT;
                    end else if (dec.is_halt) begin
                        state_nx = HALT;
                    end else begin
                        state_nx = EXECUTE;
                    end
                end
                EXECUTE: begin
                    alua_src   = dec.alua_src;
                    alub_src   = dec.alub_src;
                    aluy_src   = dec.aluy_src;
                    alu_src    = dec.alu_src;
                    sub        = dec.sub;
                    arithmetic = dec.arithmetic;
                    alupc_src  = dec.alupc_src;
                    if (dec.is_mem) begin
                        mem_addr_src = 1'b1;
                        if (done) begin
                            pc_en      = 1'b1;
                            wr_reg_en  = dec.is_load;
                            wr_reg_src = dec.is_load ? WB_MEM : WB_ALU;
                            state_nx   = FETCH;
                        end else if (expired) begin
                            state_nx = HALT;
                        end else begin
                            mem_rd_en   = dec.is_load;
                            mem_wr_en   = !dec.is_load;
                            mem_byte_en = dec.byte_mask[BYTE_NUM-1:0];
                        end
                    end else begin
                        pc_en      = 1'b1;
                        pc_src     = dec.jump | (dec.is_branch & taken);
                        wr_reg_en  = dec.wr_reg;
                        wr_reg_src = dec.wr_reg_src;
                        state_nx   = FETCH;
                    end
                end
                HALT:    state_nx = HALT;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign halted        = !reset && (state == HALT);
    assign illegal_instr = !reset && illegal_q;
    assign bus_timeout   = !reset && timeout_q;

endmodule

// File: tb/tb_control_unit_mc.sv
module tb_control_unit_mc;
    import control_unit_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // RV32 instance
    logic       reset = 1'b1, mem_busy = 1'b0;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
    logic       mem_rd_en, mem_wr_en, ir_en, pc_en, wr_reg_en;
    logic [3:0] mem_byte_en;
    logic       alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, mem_addr_src;
    logic [2:0] alu_src;
    logic [1:0] wr_reg_src;
    logic       halted, illegal_instr, bus_timeout;

    // RV64 instance
    logic       r64 = 1'b1, b64 = 1'b0;
    logic [6:0] op64 = '0;
    logic [2:0] f364 = '0;
    logic       rd64, wr64, ir64, pc64, wre64;
    logic [7:0] be64;
    logic       as64, bs64, ys64, sub64, ar64, aps64, ps64, mas64, h64, ii64, bt64;
    logic [2:0] alu64;
    logic [1:0] wrs64;

    int checks = 0;
    int errors = 0;

    wire [4:0]  en       = {mem_rd_en, mem_wr_en, ir_en, pc_en, wr_reg_en};
    wire [27:0] all_outs = {en, mem_byte_en, alua_src, alub_src, aluy_src, alu_src, sub, arithmetic,
                            alupc_src, pc_src, wr_reg_src, mem_addr_src, halted, illegal_instr, bus_timeout};

    control_unit_mc #(.RV64I(0), .BYTE_NUM(4), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .mem_busy(mem_busy),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en),
        .ir_en(ir_en), .pc_en(pc_en), .wr_reg_en(wr_reg_en),
        .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src), .alu_src(alu_src),
        .sub(sub), .arithmetic(arithmetic), .alupc_src(alupc_src), .pc_src(pc_src),
        .wr_reg_src(wr_reg_src), .mem_addr_src(mem_addr_src),
        .halted(halted), .illegal_instr(illegal_instr), .bus_timeout(bus_timeout)
    );

    control_unit_mc #(.RV64I(1), .BYTE_NUM(8), .TIMEOUT_CYCLES(8)) dut64 (
        .clock(clock), .reset(r64), .mem_busy(b64),
        .opcode(op64), .funct3(f364), .funct7(7'h00),
        .zero(1'b0), .negative(1'b0), .carry_out(1'b0), .overflow(1'b0),
        .mem_rd_en(rd64), .mem_wr_en(wr64), .mem_byte_en(be64),
        .ir_en(ir64), .pc_en(pc64), .wr_reg_en(wre64),
        .alua_src(as64), .alub_src(bs64), .aluy_src(ys64), .alu_src(alu64),
        .sub(sub64), .arithmetic(ar64), .alupc_src(aps64), .pc_src(ps64),
        .wr_reg_src(wrs64), .mem_addr_src(mas64),
        .halted(h64), .illegal_instr(ii64), .bus_timeout(bt64)
    );

    // Fetch with nbusy busy cycles, complete with the given instruction, then DECODE.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input int nbusy);
        for (int i = 0; i < nbusy; i++) begin
            @(negedge clock); mem_busy = 1'b1; #1;
            checks++;
            if (en !== 5'b10000 || mem_addr_src !== 1'b0 || mem_byte_en !== 4'hF) begin
                errors++;
                $display("FAIL fetch_req: en=%b addr_src=%b be=%h, expected en=10000 addr_src=0 be=f", en, mem_addr_src, mem_byte_en);
            end
        end
        @(negedge clock); mem_busy = 1'b0; opcode = op; funct3 = f3; funct7 = f7; #1;
        checks++;
        if (en !== 5'b00100) begin
            errors++;
            $display("FAIL fetch_done: en=%b, expected 00100", en);
        end
        @(negedge clock); #1;
        checks++;
        if (en !== 5'b00000) begin
            errors++;
            $display("FAIL decode_idle: en=%b, expected 00000", en);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_busy = 1'b0;
        repeat (2) begin
            @(negedge clock); #1;
            checks++;
            if (all_outs !== '0) begin
                errors++;
                $display("FAIL reset_outs: %h, expected 0", all_outs);
            end
        end
        @(negedge clock); reset = 1'b0; #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL release_idle: %h, expected 0", all_outs);
        end
        @(negedge clock); #1;
        checks++;
        if (en !== 5'b10000 || mem_byte_en !== 4'hF) begin
            errors++;
            $display("FAIL first_fetch: en=%b be=%h, expected en=10000 be=f", en, mem_byte_en);
        end
    endtask

    task automatic test_addi;
        fetch_decode(OP_IMM, 3'b000, 7'h05, 2);
        @(negedge clock); #1;
        checks++;
        if (en !== 5'b00011 || alub_src !== 1'b1 || alua_src !== 1'b0 || alu_src !== 3'b000 ||
            wr_reg_src !== WB_ALU || pc_src !== 1'b0) begin
            errors++;
            $display("FAIL addi_exec: en=%b bsrc=%b asrc=%b alu=%b wrs=%b pcs=%b, expected 00011 1 0 000 00 0",
                     en, alub_src, alua_src, alu_src, wr_reg_src, pc_src);
        end
    endtask

    task automatic mem_op(input bit store, input logic [2:0] f3, input logic [3:0] mask);
        fetch_decode(store ? STORE : LOAD, f3, 7'h00, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); mem_busy = 1'b1; #1;
            checks++;
            if (en !== (store ? 5'b01000 : 5'b10000) || mem_byte_en !== mask || mem_addr_src !== 1'b1) begin
                errors++;
                $display("FAIL mem_req f3=%b: en=%b be=%h addr_src=%b, expected st=%0d be=%h addr_src=1",
                         f3, en, mem_byte_en, mem_addr_src, store, mask);
            end
        end
        @(negedge clock); mem_busy = 1'b0; #1;
        checks++;
        if (en !== (store ? 5'b00010 : 5'b00011) || (!store && wr_reg_src !== WB_MEM) || pc_src !== 1'b0) begin
            errors++;
            $display("FAIL mem_done f3=%b: en=%b wrs=%b pcs=%b, expected st=%0d", f3, en, wr_reg_src, pc_src, store);
        end
    endtask

    task automatic test_load_store;
        mem_op(1'b0, 3'b010, 4'hF);  // LW
        mem_op(1'b1, 3'b010, 4'hF);  // SW
        mem_op(1'b0, 3'b100, 4'h1);  // LBU
        mem_op(1'b1, 3'b001, 4'h3);  // SH
    endtask

    task automatic test_branch;
        logic [2:0] f3s  [4] = '{3'b110, 3'b101, 3'b000, 3'b001};
        logic [2:0] flg  [4] = '{3'b000, 3'b100, 3'b001, 3'b001};  // {negative, overflow, zero}
        logic       exp_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        carry_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {negative, overflow, zero} = flg[i];
            fetch_decode(BRANCH, f3s[i], 7'h00, 1);
            @(negedge clock); #1;
            checks++;
            if (pc_src !== exp_t[i] || sub !== 1'b1 || en !== 5'b00010) begin
                errors++;
                $display("FAIL branch f3=%b: pcs=%b sub=%b en=%b, expected pcs=%b sub=1 en=00010",
                         f3s[i], pc_src, sub, en, exp_t[i]);
            end
        end
        {negative, overflow, zero} = 3'b000;
    endtask

    task automatic test_alu_ops;
        fetch_decode(JAL, 3'b000, 7'h00, 1);
        @(negedge clock); #1;
        checks++;
        if (en !== 5'b00011 || pc_src !== 1'b1 || wr_reg_src !== WB_PC4 || alupc_src !== 1'b0) begin
            errors++;
            $display("FAIL jal: en=%b pcs=%b wrs=%b aps=%b, expected 00011 1 10 0", en, pc_src, wr_reg_src, alupc_src);
        end
        fetch_decode(OP_IMM, 3'b101, 7'b0100000, 1);  // SRAI
        @(negedge clock); #1;
        checks++;
        if (arithmetic !== 1'b1 || alu_src !== 3'b101 || alub_src !== 1'b1 || sub !== 1'b0 || en !== 5'b00011) begin
            errors++;
            $display("FAIL srai: ar=%b alu=%b bsrc=%b sub=%b en=%b, expected 1 101 1 0 00011", arithmetic, alu_src, alub_src, sub, en);
        end
        fetch_decode(OP, 3'b000, 7'b0100000, 1);  // SUB
        @(negedge clock); #1;
        checks++;
        if (sub !== 1'b1 || alub_src !== 1'b0 || arithmetic !== 1'b0 || alu_src !== 3'b000 || en !== 5'b00011) begin
            errors++;
            $display("FAIL sub: sub=%b bsrc=%b ar=%b alu=%b en=%b, expected 1 0 0 000 00011", sub, alub_src, arithmetic, alu_src, en);
        end
    endtask

    task automatic test_illegal;
        fetch_decode(OP_32, 3'b000, 7'h00, 1);  // ADDW without RV64
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            checks++;
            if (en !== 5'b00000 || halted !== 1'b1 || illegal_instr !== 1'b1 || bus_timeout !== 1'b0) begin
                errors++;
                $display("FAIL addw_halt c%0d: en=%b h=%b ii=%b bt=%b, expected 00000 1 1 0", i, en, halted, illegal_instr, bus_timeout);
            end
        end
        test_reset;
        fetch_decode(BRANCH, 3'b010, 7'h00, 1);  // funct3 01x is not a branch
        @(negedge clock); #1;
        checks++;
        if (halted !== 1'b1 || illegal_instr !== 1'b1) begin
            errors++;
            $display("FAIL branch_01x: h=%b ii=%b, expected 1 1", halted, illegal_instr);
        end
        test_reset;
    endtask

    task automatic test_ecall;
        fetch_decode(SYSTEM, 3'b000, 7'h00, 1);
        @(negedge clock); #1;
        checks++;
        if (halted !== 1'b1 || illegal_instr !== 1'b0 || bus_timeout !== 1'b0 || en !== 5'b00000) begin
            errors++;
            $display("FAIL ecall: h=%b ii=%b bt=%b en=%b, expected 1 0 0 00000", halted, illegal_instr, bus_timeout, en);
        end
        test_reset;
    endtask

    // test_reset leaves us having sampled the first FETCH cycle (count 0).
    task automatic test_timeout;
        mem_busy = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clock); #1;
            checks++;
            if (mem_rd_en !== 1'b1 || halted !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold c%0d: rd=%b h=%b, expected 1 0", i, mem_rd_en, halted);
            end
        end
        @(negedge clock); #1;
        checks++;
        if (en !== 5'b00000 || mem_byte_en !== 4'h0) begin
            errors++;
            $display("FAIL tmo_drop: en=%b be=%h, expected 00000 0", en, mem_byte_en);
        end
        @(negedge clock); #1;
        checks++;
        if (halted !== 1'b1 || bus_timeout !== 1'b1 || illegal_instr !== 1'b0 || en !== 5'b00000) begin
            errors++;
            $display("FAIL tmo_halt: h=%b bt=%b ii=%b en=%b, expected 1 1 0 00000", halted, bus_timeout, illegal_instr, en);
        end
    endtask

    task automatic test_rv64_ld;
        @(negedge clock); #1;
        checks++;
        if (be64 !== 8'h00 || rd64 !== 1'b0) begin
            errors++;
            $display("FAIL rv64_reset: be=%h rd=%b, expected 00 0", be64, rd64);
        end
        @(negedge clock); r64 = 1'b0; #1;
        @(negedge clock); #1;
        checks++;
        if (rd64 !== 1'b1 || be64 !== 8'h0F) begin
            errors++;
            $display("FAIL rv64_fetch: rd=%b be=%h, expected 1 0f", rd64, be64);
        end
        @(negedge clock); b64 = 1'b1; #1;
        @(negedge clock); b64 = 1'b0; op64 = LOAD; f364 = 3'b011; #1;
        checks++;
        if (ir64 !== 1'b1 || rd64 !== 1'b0) begin
            errors++;
            $display("FAIL rv64_ir: ir=%b rd=%b, expected 1 0", ir64, rd64);
        end
        @(negedge clock); #1;  // DECODE
        @(negedge clock); b64 = 1'b1; #1;
        checks++;
        if (rd64 !== 1'b1 || be64 !== 8'hFF || mas64 !== 1'b1 || h64 !== 1'b0) begin
            errors++;
            $display("FAIL ld_req: rd=%b be=%h as=%b h=%b, expected 1 ff 1 0", rd64, be64, mas64, h64);
        end
        @(negedge clock); b64 = 1'b0; #1;
        checks++;
        if (rd64 !== 1'b0 || pc64 !== 1'b1 || wre64 !== 1'b1 || wrs64 !== WB_MEM) begin
            errors++;
            $display("FAIL ld_done: rd=%b pc=%b wr=%b wrs=%b, expected 0 1 1 01", rd64, pc64, wre64, wrs64);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_store;
        test_branch;
        test_alu_ops;
        test_illegal;
        test_ecall;
        test_timeout;
        test_rv64_ld;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
